// File: rtl/nn_wu_pkg.sv
// Shared constants for the weight-update unit: FloPoCo exception tags, seed ROM words
// and the address-width helper.
package nn_wu_pkg;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam int unsigned FP_W = 34;

  localparam logic [FP_W-1:0] ROM_W0 = {EXC_NORMAL, 32'h3A83126F};
  localparam logic [FP_W-1:0] ROM_W1 = {EXC_NORMAL, 32'h38D1B717};

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Seed pattern repeats for memories deeper than the two ROM words.
  function automatic logic [FP_W-1:0] rom_word(input int unsigned idx);
    return idx[0] ? ROM_W1 : ROM_W0;
  endfunction

endpackage

// File: rtl/nn_weight_update_unit_fp_addsub34.sv
// Combinational 34-bit FloPoCo float add/subtract (tag + IEEE single), round-to-nearest-even.
// Subnormal results flush to zero, as FloPoCo has no denormals.
module fp_addsub34
  import nn_wu_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  output logic [FP_W-1:0] sum_c
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] cnt;
    logic       found;
    cnt   = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        cnt   = 5'(26 - i);
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  logic [1:0]  ta, tb;
  logic        sa, sb, sx, eff_sub, b_larger, underflow;
  logic [7:0]  ex, ey, d;
  logic [4:0]  dsh, lz;
  logic [23:0] mx, my;
  logic [50:0] yw;
  logic [26:0] xm, ym, n;
  logic [27:0] s;
  logic [9:0]  e, e_f;
  logic        rnd;
  logic [24:0] mr;
  logic [FP_W-1:0] norm;
  logic        unused_hidden;

  assign unused_hidden = mr[23];

  always_comb begin
    ta       = a[33:32];
    tb       = b[33:32];
    sa       = a[31];
    sb       = b[31] ^ sub;
    eff_sub  = sa ^ sb;
    b_larger = (b[30:0] > a[30:0]);
    sx       = b_larger ? sb : sa;
    ex       = b_larger ? b[30:23] : a[30:23];
    ey       = b_larger ? a[30:23] : b[30:23];
    mx       = {1'b1, (b_larger ? b[22:0] : a[22:0])};
    my       = {1'b1, (b_larger ? a[22:0] : b[22:0])};
    d        = ex - ey;
    dsh      = (d > 8'd27) ? 5'd27 : d[4:0];

    // Align smaller operand keeping guard, round and a sticky OR of everything shifted out.
    yw = {my, 27'b0} >> dsh;
    xm = {mx, 3'b000};
    ym = {yw[50:25], |yw[24:0]};
    s  = eff_sub ? ({1'b0, xm} - {1'b0, ym}) : ({1'b0, xm} + {1'b0, ym});
    lz = lzc27(s[26:0]);

    underflow = 1'b0;
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = {2'b00, ex} + 10'd1;
    end else begin
      n = s[26:0] << lz;
      e = {2'b00, ex} - {5'b00000, lz};
      underflow = ({3'b000, lz} >= ex);
    end

    rnd = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[26:3]} + 25'(rnd);
    e_f = e + 10'(mr[24]);

    if (s == 28'd0)
      norm = {EXC_ZERO, 32'h0};
    else if (underflow)
      norm = {EXC_ZERO, sx, 31'h0};
    else if (e_f >= 10'd255)
      norm = {EXC_INF, sx, 8'hFF, 23'h0};
    else
      norm = {EXC_NORMAL, sx, e_f[7:0], mr[22:0]};

    if (ta == EXC_NAN || tb == EXC_NAN)
      sum_c = {EXC_NAN, 32'h7FC00000};
    else if (ta == EXC_INF && tb == EXC_INF)
      sum_c = eff_sub ? {EXC_NAN, 32'h7FC00000} : {EXC_INF, sa, 8'hFF, 23'h0};
    else if (ta == EXC_INF)
      sum_c = {EXC_INF, sa, 8'hFF, 23'h0};
    else if (tb == EXC_INF)
      sum_c = {EXC_INF, sb, 8'hFF, 23'h0};
    else if (ta == EXC_ZERO && tb == EXC_ZERO)
      sum_c = {EXC_ZERO, sa & sb, 31'h0};
    else if (ta == EXC_ZERO)
      sum_c = {EXC_NORMAL, sb, b[30:0]};
    else if (tb == EXC_ZERO)
      sum_c = a;
    else
      sum_c = norm;
  end

endmodule

// File: rtl/nn_weight_update_unit.sv
// Manhattan-rule weight update over a small ROM-seeded weight RAM.
// Optional best-weights buffer enabled by defining BEST_WEIGHTS_BUF_EN.
module nn_weight_update_unit
  import nn_wu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 2,
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned EXTRA_BITS = 2
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             training_mode,
  input  logic [EXTRA_BITS+BIT_WIDTH-1:0]  l2_error,
  input  logic [EXTRA_BITS+BIT_WIDTH-1:0]  delta_val,
  input  logic                             local_initial_read_flag,
  input  logic                             local_finish,
  input  logic                             stall,
  input  logic                             training_rd,
  input  logic                             training_wr,
  input  logic                             test_write_buffer_bestweights,
  output logic [EXTRA_BITS+BIT_WIDTH-1:0]  weight_out,
  output logic                             weight_valid,
  output logic [EXTRA_BITS+BIT_WIDTH-1:0]  rd_data,
  output logic [EXTRA_BITS+BIT_WIDTH-1:0]  best_weight_out,
  output logic                             done
);

  localparam int unsigned FW = EXTRA_BITS + BIT_WIDTH;
  localparam int unsigned WW = EXTRA_BITS + DATA_WIDTH;
  localparam int unsigned AW = addr_width(RAM_DEPTH);

  logic [WW-1:0] ram [RAM_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt_c, rd_ptr_nxt_c;
  logic [WW-1:0] operand_c, addsub_c, w_new_c;
  logic          do_update_c, do_read_c;
  logic          unused_l2;

  assign unused_l2 = ^l2_error[BIT_WIDTH-2:0];

  always_comb begin
    do_update_c = !stall && !done && training_wr
                  && (l2_error[FW-1 -: EXTRA_BITS] == EXC_NORMAL)
                  && (delta_val[FW-1 -: EXTRA_BITS] == EXC_NORMAL);
    do_read_c    = !stall && training_rd;
    operand_c    = local_initial_read_flag ? rom_word(32'(wr_ptr)) : ram[wr_ptr];
    w_new_c      = training_mode ? addsub_c : operand_c;
    wr_ptr_nxt_c = (wr_ptr == AW'(RAM_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    rd_ptr_nxt_c = (rd_ptr == AW'(RAM_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
  end

  // Positive error steps the weight up, negative error steps it down.
  fp_addsub34 u_addsub (
    .a     (operand_c),
    .b     (delta_val),
    .sub   (l2_error[BIT_WIDTH-1]),
    .sum_c (addsub_c)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= rom_word(i);
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      weight_out   <= '0;
      weight_valid <= 1'b0;
      rd_data      <= '0;
      done         <= 1'b0;
    end else begin
      weight_valid <= do_update_c;
      if (do_update_c) begin
        ram[wr_ptr] <= w_new_c;
        weight_out  <= w_new_c;
        wr_ptr      <= wr_ptr_nxt_c;
      end
      if (do_read_c) begin
        rd_data <= ram[rd_ptr];
        rd_ptr  <= rd_ptr_nxt_c;
      end
      if (!stall && local_finish) done <= 1'b1;
    end
  end

`ifdef BEST_WEIGHTS_BUF_EN
  logic [WW-1:0] best [RAM_DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < RAM_DEPTH; i++) best[i] <= rom_word(i);
      best_weight_out <= '0;
    end else begin
      if (do_update_c && test_write_buffer_bestweights) best[wr_ptr] <= w_new_c;
      if (do_read_c) best_weight_out <= best[rd_ptr];
    end
  end
`else
  logic unused_best;

  assign unused_best     = test_write_buffer_bestweights;
  assign best_weight_out = '0;
`endif

endmodule

// File: tb/tb_nn_weight_update_unit.sv
// Directed self-checking bench for nn_weight_update_unit; expected words are hand-computed floats.
module tb_nn_weight_update_unit;

  localparam logic [33:0] ROM0   = {2'b01, 32'h3A83126F};
  localparam logic [33:0] ROM1   = {2'b01, 32'h38D1B717};
  localparam logic [33:0] L2_POS = {2'b01, 32'h3A83126F};
  localparam logic [33:0] L2_NEG = {2'b01, 32'hBA83126F};
  localparam logic [33:0] DELTA  = {2'b01, 32'h3DCCCCCD};
  localparam logic [33:0] W1     = {2'b01, 32'h3DCED917};
  localparam logic [33:0] W2     = {2'b01, 32'h3DCD013B};
  localparam logic [33:0] W3     = {2'b01, 32'h3E4DD2F2};
  localparam logic [33:0] WNEG   = {2'b01, 32'hBDCAC083};
`ifdef BEST_WEIGHTS_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, training_mode, local_initial_read_flag, local_finish, stall;
  logic        training_rd, training_wr, test_write_buffer_bestweights;
  logic [33:0] l2_error, delta_val;
  logic [33:0] weight_out, rd_data, best_weight_out;
  logic        weight_valid, done;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  nn_weight_update_unit dut (
    .CLK(CLK), .RESET(RESET), .training_mode(training_mode), .l2_error(l2_error),
    .delta_val(delta_val), .local_initial_read_flag(local_initial_read_flag),
    .local_finish(local_finish), .stall(stall), .training_rd(training_rd),
    .training_wr(training_wr), .test_write_buffer_bestweights(test_write_buffer_bestweights),
    .weight_out(weight_out), .weight_valid(weight_valid), .rd_data(rd_data),
    .best_weight_out(best_weight_out), .done(done)
  );

  task automatic reset_pulse();
    RESET = 1'b1; training_mode = 1'b1; local_initial_read_flag = 1'b1; local_finish = 1'b0;
    stall = 1'b0; training_rd = 1'b0; training_wr = 1'b0; test_write_buffer_bestweights = 1'b0;
    l2_error = L2_POS; delta_val = DELTA;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    reset_pulse();
    checks++; if (weight_out !== 34'h0) begin failures++; $display("FAIL reset_weight got=%h exp=0", weight_out); end
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", weight_valid); end
    checks++; if (rd_data !== 34'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (best_weight_out !== 34'h0) begin failures++; $display("FAIL reset_best got=%h exp=0", best_weight_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_rom_updates();
    test_write_buffer_bestweights = 1'b1;
    training_wr = 1'b1;
    @(negedge CLK);
    training_wr = 1'b0;
    checks++; if (weight_out !== W1) begin failures++; $display("FAIL upd1_weight got=%h exp=%h", weight_out, W1); end
    checks++; if (weight_valid !== 1'b1) begin failures++; $display("FAIL upd1_valid got=%b exp=1", weight_valid); end
    @(negedge CLK);
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL upd1_valid_pulse got=%b exp=0", weight_valid); end
    training_wr = 1'b1;
    @(negedge CLK);
    training_wr = 1'b0;
    test_write_buffer_bestweights = 1'b0;
    checks++; if (weight_out !== W2) begin failures++; $display("FAIL upd2_weight got=%h exp=%h", weight_out, W2); end
    checks++; if (weight_valid !== 1'b1) begin failures++; $display("FAIL upd2_valid got=%b exp=1", weight_valid); end
  endtask

  task automatic test_best_read();
    training_rd = 1'b1;
    @(negedge CLK);
    checks++; if (rd_data !== W1) begin failures++; $display("FAIL rd0_data got=%h exp=%h", rd_data, W1); end
    checks++; if (best_weight_out !== (BUF_EN ? W1 : 34'h0)) begin failures++; $display("FAIL rd0_best got=%h exp=%h", best_weight_out, (BUF_EN ? W1 : 34'h0)); end
    @(negedge CLK);
    training_rd = 1'b0;
    checks++; if (rd_data !== W2) begin failures++; $display("FAIL rd1_data got=%h exp=%h", rd_data, W2); end
    checks++; if (best_weight_out !== (BUF_EN ? W2 : 34'h0)) begin failures++; $display("FAIL rd1_best got=%h exp=%h", best_weight_out, (BUF_EN ? W2 : 34'h0)); end
  endtask

  task automatic test_ram_update();
    local_initial_read_flag = 1'b0;
    training_wr = 1'b1;
    @(negedge CLK);
    training_wr = 1'b0;
    checks++; if (weight_out !== W3) begin failures++; $display("FAIL upd3_weight got=%h exp=%h", weight_out, W3); end
    training_rd = 1'b1;
    @(negedge CLK);
    training_rd = 1'b0;
    checks++; if (rd_data !== W3) begin failures++; $display("FAIL rd_wrap_data got=%h exp=%h", rd_data, W3); end
    checks++; if (best_weight_out !== (BUF_EN ? W1 : 34'h0)) begin failures++; $display("FAIL rd_wrap_best got=%h exp=%h", best_weight_out, (BUF_EN ? W1 : 34'h0)); end
  endtask

  task automatic test_negative_and_stall();
    reset_pulse();
    l2_error = L2_NEG;
    training_wr = 1'b1;
    @(negedge CLK);
    training_wr = 1'b0;
    checks++; if (weight_out !== WNEG) begin failures++; $display("FAIL neg_weight got=%h exp=%h", weight_out, WNEG); end
    stall = 1'b1; training_wr = 1'b1; training_rd = 1'b1; local_finish = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (weight_out !== WNEG) begin failures++; $display("FAIL stall_weight got=%h exp=%h", weight_out, WNEG); end
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL stall_valid got=%b exp=0", weight_valid); end
    checks++; if (rd_data !== 34'h0) begin failures++; $display("FAIL stall_rd_data got=%h exp=0", rd_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stall_done got=%b exp=0", done); end
    stall = 1'b0; training_rd = 1'b0; local_finish = 1'b0; training_mode = 1'b0;
    @(negedge CLK);
    training_wr = 1'b0;
    checks++; if (weight_out !== ROM1) begin failures++; $display("FAIL hold_weight got=%h exp=%h", weight_out, ROM1); end
    checks++; if (weight_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", weight_valid); end
    training_rd = 1'b1;
    @(negedge CLK);
    training_rd = 1'b0;
    checks++; if (rd_data !== WNEG) begin failures++; $display("FAIL post_stall_rd got=%h exp=%h", rd_data, WNEG); end
  endtask

  task automatic test_exceptions();
    training_mode = 1'b1;
    l2_error = {2'b00, 32'h0};
    training_wr = 1'b1;
    @(negedge CLK);
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL l2_zero_valid got=%b exp=0", weight_valid); end
    l2_error = L2_POS;
    delta_val = {2'b11, 32'h7FC00000};
    @(negedge CLK);
    training_wr = 1'b0;
    delta_val = DELTA;
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL delta_nan_valid got=%b exp=0", weight_valid); end
    checks++; if (weight_out !== ROM1) begin failures++; $display("FAIL exc_weight got=%h exp=%h", weight_out, ROM1); end
  endtask

  task automatic test_finish();
    reset_pulse();
    training_wr = 1'b1; training_rd = 1'b1;
    @(negedge CLK);
    training_wr = 1'b0; training_rd = 1'b0;
    checks++; if (rd_data !== ROM0) begin failures++; $display("FAIL rbw_rd_data got=%h exp=%h", rd_data, ROM0); end
    checks++; if (weight_out !== W1) begin failures++; $display("FAIL rbw_weight got=%h exp=%h", weight_out, W1); end
    local_finish = 1'b1;
    @(negedge CLK);
    local_finish = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL finish_done got=%b exp=1", done); end
    training_wr = 1'b1;
    @(negedge CLK);
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL finish_valid got=%b exp=0", weight_valid); end
    checks++; if (weight_out !== W1) begin failures++; $display("FAIL finish_weight got=%h exp=%h", weight_out, W1); end
    training_rd = 1'b1;
    @(negedge CLK);
    training_rd = 1'b0;
    checks++; if (rd_data !== ROM1) begin failures++; $display("FAIL finish_rd got=%h exp=%h", rd_data, ROM1); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_sticky got=%b exp=1", done); end
  endtask

  task automatic test_async_reset();
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    checks++; if (weight_out !== 34'h0) begin failures++; $display("FAIL areset_weight got=%h exp=0", weight_out); end
    checks++; if (rd_data !== 34'h0) begin failures++; $display("FAIL areset_rd got=%h exp=0", rd_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", done); end
    @(negedge CLK);
    training_wr = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    checks++; if (weight_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", weight_valid); end
    training_rd = 1'b1;
    @(negedge CLK);
    training_rd = 1'b0;
    checks++; if (rd_data !== ROM0) begin failures++; $display("FAIL areset_ram got=%h exp=%h", rd_data, ROM0); end
  endtask

  initial begin
    RESET = 1'b1;
    test_reset();
    test_rom_updates();
    test_best_read();
    test_ram_update();
    test_negative_and_stall();
    test_exceptions();
    test_finish();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
